// File: rtl/wait_gen.sv
// Wait-state generator for the 6809E bus: holds MRDY low to stretch E per chip-select region,
// with EXT/EXTIO cycles further extendable by EXT_nWAIT up to a timeout that raises BUSERR.
module wait_gen #(
    parameter logic [3:0] WS_ROM      = 4'd0,
    parameter logic [3:0] WS_RAM      = 4'd0,
    parameter logic [3:0] WS_UART     = 4'd2,
    parameter logic [3:0] WS_EXT      = 4'd1,
    parameter logic [3:0] WS_EXTIO    = 4'd3,
    parameter logic [7:0] EXT_TIMEOUT = 8'd255
) (
    input  logic CLKX4,
    input  logic nRESET,
    input  logic QX,
    input  logic EX,
    input  logic BA,
    input  logic nCSROM0,
    input  logic nCSROM1,
    input  logic nCSRAM,
    input  logic nCSEXT,
    input  logic nCSEXTIO,
    input  logic nCSUART,
    input  logic EXT_nWAIT,
    input  logic CLRERR,
    output logic MRDY,
    output logic BUSERR
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [7:0] tocnt, tocnt_nx;
    logic       ext, ext_nx;
    logic       mrdy_nx, buserr_nx;

    logic [3:0] ws_sel;
    logic       ext_sel, any_sel;
    logic       ph_launch, ph_hold;

    // 11 is the phase where the cycle is launched; 01 is the phase the generator stretches.
    assign ph_launch = QX & EX;
    assign ph_hold   = ~QX & EX;

    always_comb begin
        ws_sel  = 4'd0;
        ext_sel = 1'b0;
        any_sel = 1'b1;
        if (!nCSEXTIO) begin
            ws_sel  = WS_EXTIO;
            ext_sel = 1'b1;
        end else if (!nCSUART) begin
            ws_sel  = WS_UART;
        end else if (!nCSEXT) begin
            ws_sel  = WS_EXT;
            ext_sel = 1'b1;
        end else if (!nCSROM0 || !nCSROM1) begin
            ws_sel  = WS_ROM;
        end else if (!nCSRAM) begin
            ws_sel  = WS_RAM;
        end else begin
            any_sel = 1'b0;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        tocnt_nx  = tocnt;
        ext_nx    = ext;
        mrdy_nx   = MRDY;
        // A timeout on the same edge as CLRERR overrides this below.
        buserr_nx = BUSERR & ~CLRERR;
        case (state)
            IDLE: begin
                if (ph_launch) begin
                    mrdy_nx = 1'b1;
                    if (!BA && any_sel) begin
                        cnt_nx   = ws_sel;
                        ext_nx   = ext_sel;
                        tocnt_nx = 8'd0;
                        if (ws_sel != 4'd0 || ext_sel) begin
                            mrdy_nx  = 1'b0;
                            state_nx = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                // Selects and a stray 11 phase are ignored here; the region was latched at launch.
                if (ph_hold) begin
                    if (cnt > 4'd1) begin
                        cnt_nx = cnt - 4'd1;
                    end else if (!ext) begin
                        cnt_nx   = 4'd0;
                        mrdy_nx  = 1'b1;
                        state_nx = IDLE;
                    end else if (EXT_nWAIT) begin
                        mrdy_nx  = 1'b1;
                        state_nx = IDLE;
                    end else if (tocnt == EXT_TIMEOUT) begin
                        mrdy_nx   = 1'b1;
                        buserr_nx = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        tocnt_nx = tocnt + 8'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLKX4) begin
        if (!nRESET) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            tocnt  <= 8'd0;
            ext    <= 1'b0;
            MRDY   <= 1'b1;
            BUSERR <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            tocnt  <= tocnt_nx;
            ext    <= ext_nx;
            MRDY   <= mrdy_nx;
            BUSERR <= buserr_nx;
        end
    end

endmodule

// File: tb/tb_wait_gen.sv
// Bench for wait_gen: a bench-side E/Q generator runs bus cycles from a vector table,
// then hand sequences cover reset mid-wait, stray 11, sticky BUSERR and set-vs-clear.
module tb_wait_gen;

    logic CLKX4 = 1'b0;
    logic nRESET, QX, EX, BA, EXT_nWAIT, CLRERR;
    logic nCSROM0, nCSROM1, nCSRAM, nCSEXT, nCSEXTIO, nCSUART;
    logic MRDY, BUSERR, MRDY_TO, BUSERR_TO;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [5:0] S_ROM0 = 6'b100000, S_ROM1 = 6'b010000, S_RAM = 6'b001000;
    localparam logic [5:0] S_EXT  = 6'b000100, S_EXTIO = 6'b000010, S_UART = 6'b000001;

    always #5 CLKX4 = ~CLKX4;

    wait_gen dut (
        .CLKX4(CLKX4), .nRESET(nRESET), .QX(QX), .EX(EX), .BA(BA),
        .nCSROM0(nCSROM0), .nCSROM1(nCSROM1), .nCSRAM(nCSRAM), .nCSEXT(nCSEXT),
        .nCSEXTIO(nCSEXTIO), .nCSUART(nCSUART), .EXT_nWAIT(EXT_nWAIT), .CLRERR(CLRERR),
        .MRDY(MRDY), .BUSERR(BUSERR)
    );

    wait_gen #(.EXT_TIMEOUT(8'd4)) dut_to (
        .CLKX4(CLKX4), .nRESET(nRESET), .QX(QX), .EX(EX), .BA(BA),
        .nCSROM0(nCSROM0), .nCSROM1(nCSROM1), .nCSRAM(nCSRAM), .nCSEXT(nCSEXT),
        .nCSEXTIO(nCSEXTIO), .nCSUART(nCSUART), .EXT_nWAIT(EXT_nWAIT), .CLRERR(CLRERR),
        .MRDY(MRDY_TO), .BUSERR(BUSERR_TO)
    );

    typedef struct {
        string      name;
        logic [5:0] sel;
        logic       ba;
        int         nw;       // 01 edges (from the first) with EXT_nWAIT low
        logic       use_to;   // generator follows the EXT_TIMEOUT=4 instance
        int         exp_low;  // edges after which MRDY reads 0
        int         exp_eh;   // CLKX4 periods with E high
        logic       exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cs(input logic [5:0] sel);
        {nCSROM0, nCSROM1, nCSRAM, nCSEXT, nCSEXTIO, nCSUART} = ~sel;
    endtask

    task automatic step(input logic [1:0] g);
        {QX, EX} = g;
        @(posedge CLKX4);
        #1;
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        step(2'b00);
        step(2'b00);
        nRESET = 1'b1;
    endtask

    // One full E cycle, starting in 00 and ending when the generator leaves 01.
    task automatic bus_cycle(input logic [5:0] sel, input logic ba, input int nw, input logic use_to,
                             output int low, output int eh, output logic err, output logic hung);
        logic [1:0] g;
        logic pre, done;
        int n01;
        g = 2'b00; done = 1'b0; n01 = 0; low = 0; eh = 0;
        set_cs(sel);
        BA = ba;
        for (int i = 0; i < 200 && !done; i++) begin
            pre = use_to ? MRDY_TO : MRDY;
            EXT_nWAIT = !(g == 2'b01 && n01 < nw);
            step(g);
            if (g == 2'b01) n01++;
            if (g[0]) eh++;
            if (!(use_to ? MRDY_TO : MRDY)) low++;
            case (g)
                2'b00: g = 2'b10;
                2'b10: g = 2'b11;
                2'b11: g = 2'b01;
                default: if (pre) begin g = 2'b00; done = 1'b1; end
            endcase
        end
        err  = use_to ? BUSERR_TO : BUSERR;
        hung = !done;
        {QX, EX} = 2'b00;
        set_cs(6'b0);
        BA = 1'b0;
        EXT_nWAIT = 1'b1;
    endtask

    initial begin
        int low, eh;
        logic err, hung;

        nRESET = 1'b0; {QX, EX} = 2'b00; BA = 1'b0; EXT_nWAIT = 1'b1; CLRERR = 1'b0;
        set_cs(6'b0);

        vecs[0]  = '{"none",          6'b0,            1'b0, 0,   1'b0, 0, 2, 1'b0};
        vecs[1]  = '{"ram",           S_RAM,           1'b0, 0,   1'b0, 0, 2, 1'b0};
        vecs[2]  = '{"rom0",          S_ROM0,          1'b0, 0,   1'b0, 0, 2, 1'b0};
        vecs[3]  = '{"rom1",          S_ROM1,          1'b0, 0,   1'b0, 0, 2, 1'b0};
        vecs[4]  = '{"uart",          S_UART,          1'b0, 0,   1'b0, 2, 4, 1'b0};
        vecs[5]  = '{"ext_k5",        S_EXT,           1'b0, 5,   1'b0, 6, 8, 1'b0};
        vecs[6]  = '{"ext_k0",        S_EXT,           1'b0, 0,   1'b0, 1, 3, 1'b0};
        vecs[7]  = '{"extio_early",   S_EXTIO,         1'b0, 2,   1'b0, 3, 5, 1'b0};
        vecs[8]  = '{"extio_ram",     S_EXTIO | S_RAM, 1'b0, 0,   1'b0, 3, 5, 1'b0};
        vecs[9]  = '{"extio_ba",      S_EXTIO,         1'b1, 100, 1'b0, 0, 2, 1'b0};
        vecs[10] = '{"uart_ext",      S_UART | S_EXT,  1'b0, 0,   1'b0, 2, 4, 1'b0};
        vecs[11] = '{"ext_rom0",      S_EXT | S_ROM0,  1'b0, 0,   1'b0, 1, 3, 1'b0};
        vecs[12] = '{"rom0_ram",      S_ROM0 | S_RAM,  1'b0, 0,   1'b0, 0, 2, 1'b0};
        vecs[13] = '{"extio_timeout", S_EXTIO,         1'b0, 100, 1'b1, 7, 9, 1'b1};
        vecs[14] = '{"ext_k1_to",     S_EXT,           1'b0, 1,   1'b1, 2, 4, 1'b0};
        vecs[15] = '{"ext_timeout",   S_EXT,           1'b0, 100, 1'b1, 5, 7, 1'b1};

        // Reset state
        step(2'b00);
        step(2'b00);
        check("reset_mrdy", MRDY, 1);
        check("reset_buserr", BUSERR, 0);
        check("reset_mrdy_to", MRDY_TO, 1);
        check("reset_buserr_to", BUSERR_TO, 0);
        nRESET = 1'b1;

        foreach (vecs[i]) begin
            do_reset();
            bus_cycle(vecs[i].sel, vecs[i].ba, vecs[i].nw, vecs[i].use_to, low, eh, err, hung);
            check($sformatf("%s_hang", vecs[i].name), hung, 0);
            check($sformatf("%s_low", vecs[i].name), low, vecs[i].exp_low);
            check($sformatf("%s_ehigh", vecs[i].name), eh, vecs[i].exp_eh);
            check($sformatf("%s_buserr", vecs[i].name), err, vecs[i].exp_err);
        end

        // Back-to-back: UART stretch, then an unstretched RAM cycle
        do_reset();
        bus_cycle(S_UART, 1'b0, 0, 1'b0, low, eh, err, hung);
        check("b2b_uart_ehigh", eh, 4);
        bus_cycle(S_RAM, 1'b0, 0, 1'b0, low, eh, err, hung);
        check("b2b_ram_low", low, 0);
        check("b2b_ram_ehigh", eh, 2);

        // Reset mid-WAIT with cnt=2
        do_reset();
        set_cs(S_UART);
        step(2'b00); step(2'b10); step(2'b11);
        check("midrst_launch_mrdy", MRDY, 0);
        nRESET = 1'b0;
        step(2'b01);
        check("midrst_mrdy", MRDY, 1);
        nRESET = 1'b1;
        step(2'b01);
        check("midrst_idle_mrdy", MRDY, 1);
        set_cs(6'b0);

        // Stray 11 and select change during WAIT are ignored
        do_reset();
        set_cs(S_UART);
        step(2'b00); step(2'b10); step(2'b11);
        set_cs(S_EXTIO);
        step(2'b11);
        check("stray11_mrdy", MRDY, 0);
        step(2'b01);
        check("stray11_cnt1_mrdy", MRDY, 0);
        step(2'b01);
        check("stray11_release_mrdy", MRDY, 1);
        set_cs(6'b0);

        // BUSERR is sticky across cycles until CLRERR
        do_reset();
        bus_cycle(S_EXTIO, 1'b0, 100, 1'b1, low, eh, err, hung);
        check("sticky_set", err, 1);
        bus_cycle(S_RAM, 1'b0, 0, 1'b1, low, eh, err, hung);
        check("sticky_hold", err, 1);
        CLRERR = 1'b1;
        step(2'b00);
        CLRERR = 1'b0;
        check("sticky_clear", BUSERR_TO, 0);

        // Timeout and CLRERR on the same edge: set wins
        do_reset();
        set_cs(S_EXTIO);
        EXT_nWAIT = 1'b0;
        step(2'b00); step(2'b10); step(2'b11);
        for (int i = 0; i < 6; i++) step(2'b01);
        check("same_edge_pre_mrdy", MRDY_TO, 0);
        CLRERR = 1'b1;
        step(2'b01);
        check("same_edge_mrdy", MRDY_TO, 1);
        check("same_edge_buserr", BUSERR_TO, 1);
        step(2'b01);
        check("same_edge_then_clear", BUSERR_TO, 0);
        CLRERR = 1'b0;
        EXT_nWAIT = 1'b1;
        set_cs(6'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
